// File: rtl/timer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_pkg : state encodings, clock-select codes and default sizes shared by
//             the timer controller and its prescaler.       Rev 1.0
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam int TIMER_WIDTH    = 8;
  localparam int TIMER_PSC_BITS = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    DIV2  = 2'd0,
    DIV4  = 2'd1,
    DIV8  = 2'd2,
    DIV16 = 2'd3
  } clk_sel_e;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_prescaler : free-running divider with selectable tap and a registered
//                   rising-edge tick; synchronous clear and freeze.  Rev 1.0
// ---------------------------------------------------------------------------
module timer_prescaler #(
  parameter int PSC_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] sel_i,
  output logic       tick_o
);

  logic [PSC_BITS-1:0] cnt_q;
  logic [PSC_BITS-1:0] cnt_d;
  logic                tick_q;

  assign cnt_d = cnt_q + PSC_BITS'(1);

  // The tick looks at the value being loaded so it lines up with the cycle
  // in which the selected bit actually rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      if (clr_i) begin
        cnt_q <= '0;
      end else if (en_i) begin
        cnt_q <= cnt_d;
      end
      tick_q <= en_i & cnt_d[sel_i] & ~cnt_q[sel_i];
    end
  end

  assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_ctrl : command/status sequencer for the counter datapath.
//              Periodic reload enabled by TIMER_CTRL_AUTORELOAD_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH    = TIMER_WIDTH,
  parameter int PSC_BITS = TIMER_PSC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic [WIDTH-1:0] cmd_value,
  input  logic             cmd_dir,
  input  logic [1:0]       cmd_clk_sel,
  input  logic             cmd_auto_reload,
  input  logic             sts_clr,
  input  logic             overflow,
  input  logic             underflow,
  output logic             clk_ena,
  output logic [WIDTH-1:0] start_counter,
  output logic             up_down,
  output logic             load,
  output logic             enable,
  output logic             clr_overflow,
  output logic             clr_underflow,
  output logic             busy,
  output logic             irq,
  output logic             cmd_err,
  output logic             sts_ovf,
  output logic             sts_udf
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] value_q;
  logic             dir_q;
  clk_sel_e         sel_q;
  logic             accept_d;
  logic             evt_d;
  logic             reload_ok;
  logic             load_q, enable_q, busy_q, irq_q, err_q;
  logic             clr_ovf_q, clr_udf_q, sts_ovf_q, sts_udf_q;

`ifdef TIMER_CTRL_AUTORELOAD_EN
  logic ar_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q <= 1'b0;
    end else if (accept_d) begin
      ar_q <= cmd_auto_reload;
    end
  end

  assign reload_ok = ar_q;
`else
  logic unused_ar;

  assign unused_ar = cmd_auto_reload;
  assign reload_ok = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    accept_d = 1'b0;
    evt_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d  = ST_LOAD;
          accept_d = 1'b1;
        end
      end
      ST_LOAD:  state_d = cmd_stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        // A stop in the same cycle as an event swallows the event.
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (overflow | underflow) begin
          state_d = ST_CLEAR;
          evt_d   = 1'b1;
        end
      end
      ST_CLEAR: state_d = (reload_ok && !cmd_stop) ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      value_q   <= '0;
      dir_q     <= 1'b0;
      sel_q     <= DIV2;
      load_q    <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
      clr_ovf_q <= 1'b0;
      clr_udf_q <= 1'b0;
      sts_ovf_q <= 1'b0;
      sts_udf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_d) begin
        value_q <= cmd_value;
        dir_q   <= cmd_dir;
        sel_q   <= clk_sel_e'(cmd_clk_sel);
      end
      load_q    <= (state_d == ST_LOAD);
      enable_q  <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      busy_q    <= (state_d != ST_IDLE);
      irq_q     <= evt_d;
      err_q     <= cmd_start & (state_q != ST_IDLE);
      clr_ovf_q <= evt_d & overflow;
      clr_udf_q <= evt_d & underflow;
      sts_ovf_q <= (evt_d & overflow)  | (sts_ovf_q & ~sts_clr);
      sts_udf_q <= (evt_d & underflow) | (sts_udf_q & ~sts_clr);
    end
  end

  timer_prescaler #(
    .PSC_BITS (PSC_BITS)
  ) u_psc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_d == ST_LOAD),
    .en_i   ((state_q == ST_RUN) && (state_d == ST_RUN)),
    .sel_i  (sel_q),
    .tick_o (clk_ena)
  );

  assign start_counter = value_q;
  assign up_down       = dir_q;
  assign load          = load_q;
  assign enable        = enable_q;
  assign busy          = busy_q;
  assign irq           = irq_q;
  assign cmd_err       = err_q;
  assign clr_overflow  = clr_ovf_q;
  assign clr_underflow = clr_udf_q;
  assign sts_ovf       = sts_ovf_q;
  assign sts_udf       = sts_udf_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// tb_timer_ctrl : directed bench; behavioural counter plus an abstract model
// of the controller checked every cycle, with hand-computed timing literals.
module tb_timer_ctrl;

`ifdef TIMER_CTRL_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, cmd_start, cmd_stop, cmd_dir, cmd_auto_reload, sts_clr;
  logic [7:0] cmd_value;
  logic [1:0] cmd_clk_sel;
  logic       overflow, underflow;
  logic       clk_ena, up_down, load, enable, clr_overflow, clr_underflow;
  logic       busy, irq, cmd_err, sts_ovf, sts_udf;
  logic [7:0] start_counter;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  timer_ctrl dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_value(cmd_value), .cmd_dir(cmd_dir), .cmd_clk_sel(cmd_clk_sel),
    .cmd_auto_reload(cmd_auto_reload), .sts_clr(sts_clr),
    .overflow(overflow), .underflow(underflow), .clk_ena(clk_ena),
    .start_counter(start_counter), .up_down(up_down), .load(load),
    .enable(enable), .clr_overflow(clr_overflow), .clr_underflow(clr_underflow),
    .busy(busy), .irq(irq), .cmd_err(cmd_err), .sts_ovf(sts_ovf), .sts_udf(sts_udf)
  );

  // Behavioural 8-bit counter with sticky wrap flags.
  logic [7:0] cnt;
  always @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0; overflow <= 1'b0; underflow <= 1'b0;
    end else begin
      if (load) cnt <= start_counter;
      else if (enable && clk_ena) begin
        if (up_down) begin cnt <= cnt + 8'd1; if (cnt == 8'hFF) overflow <= 1'b1; end
        else begin cnt <= cnt - 8'd1; if (cnt == 8'h00) underflow <= 1'b1; end
      end
      if (clr_overflow)  overflow  <= 1'b0;
      if (clr_underflow) underflow <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tick_due(input int k, input int sel);
    int first;
    first = 1 << sel;
    return (k >= first) && (((k - first) % (2 * first)) == 0);
  endfunction

  // Reference model: phase flags, a run-cycle count and arithmetic tick timing.
  bit m_loading, m_running, m_clearing, m_dir, m_ar, m_so, m_su;
  bit e_irq, e_err, e_clro, e_clru, e_tick;
  int m_k, m_sel;
  logic [7:0] m_val;

  always @(posedge clk) begin : model
    bit idle_now, ev, start_ok;
    if (rst) begin
      m_loading = 0; m_running = 0; m_clearing = 0; m_k = 0; m_val = 8'd0;
      m_dir = 0; m_sel = 0; m_ar = 0; m_so = 0; m_su = 0;
      e_irq = 0; e_err = 0; e_clro = 0; e_clru = 0; e_tick = 0;
    end else begin
      idle_now = !(m_loading || m_running || m_clearing);
      e_err    = cmd_start && !idle_now;
      ev       = m_running && !cmd_stop && (overflow || underflow);
      e_irq    = ev;
      e_clro   = ev && overflow;
      e_clru   = ev && underflow;
      if (ev && overflow) m_so = 1; else if (sts_clr) m_so = 0;
      if (ev && underflow) m_su = 1; else if (sts_clr) m_su = 0;
      start_ok = idle_now && cmd_start;
      if (start_ok) begin
        m_val = cmd_value; m_dir = cmd_dir; m_sel = int'(cmd_clk_sel); m_ar = cmd_auto_reload;
      end
      m_k = m_running ? m_k + 1 : 0;
      e_tick     = m_running && !cmd_stop && !ev && tick_due(m_k, m_sel);
      m_running  = (m_loading && !cmd_stop) || (m_running && !cmd_stop && !ev);
      m_loading  = start_ok || (m_clearing && !cmd_stop && AR && m_ar);
      m_clearing = ev;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("load", load, m_loading);
      chk("enable", enable, m_loading || m_running);
      chk("busy", busy, m_loading || m_running || m_clearing);
      chk("clk_ena", clk_ena, e_tick);
      chk("irq", irq, e_irq);
      chk("cmd_err", cmd_err, e_err);
      chk("clr_overflow", clr_overflow, e_clro);
      chk("clr_underflow", clr_underflow, e_clru);
      chk("sts_ovf", sts_ovf, m_so);
      chk("sts_udf", sts_udf, m_su);
      chk("start_counter", start_counter, m_val);
      chk("up_down", up_down, m_dir);
    end
  end

  int load_at, first_tick, last_tick, gap, ntick, irq_at, nirq, idle_at;

  // Called at a negedge: issues a start, then observes ncyc cycles.
  task automatic go(input logic [7:0] v, input logic d, input logic [1:0] s,
                    input logic ar, input logic stp, input int ncyc);
    cmd_value = v; cmd_dir = d; cmd_clk_sel = s; cmd_auto_reload = ar;
    cmd_start = 1'b1; cmd_stop = stp;
    load_at = 0; first_tick = 0; last_tick = 0; gap = 0; ntick = 0;
    irq_at = 0; nirq = 0; idle_at = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      cmd_start = 1'b0; cmd_stop = 1'b0;
      if (load && load_at == 0) load_at = i;
      if (clk_ena) begin
        ntick++;
        if (first_tick == 0) first_tick = i; else gap = i - last_tick;
        last_tick = i;
      end
      if (irq) begin nirq++; if (irq_at == 0) irq_at = i; end
      if (!busy && idle_at == 0) idle_at = i;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; cmd_start = 0; cmd_stop = 0; cmd_value = 0; cmd_dir = 0;
    cmd_clk_sel = 0; cmd_auto_reload = 0; sts_clr = 0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_outputs", {clk_ena, start_counter, up_down, load, enable, clr_overflow,
        clr_underflow, busy, irq, cmd_err, sts_ovf, sts_udf}, 32'd0);
    rst = 0;
    @(negedge clk);

    // One-shot up from 255, DIV2, with a simultaneous stop that start overrides.
    go(8'd255, 1'b1, 2'd0, 1'b0, 1'b1, 8);
    chk("t1_load_at", load_at, 1);
    chk("t1_first_tick", first_tick, 3);
    chk("t1_irq_at", irq_at, 5);
    chk("t1_nirq", nirq, 1);
    chk("t1_idle_at", idle_at, 6);
    chk("t1_sts_ovf", sts_ovf, 1);

    sts_clr = 1; @(negedge clk); sts_clr = 0;
    chk("sts_clr_ovf", sts_ovf, 0);

    // One-shot down from 0, DIV8; sts_clr held across the event cycle.
    go(8'd0, 1'b0, 2'd2, 1'b0, 1'b0, 7);
    chk("t2_first_tick", first_tick, 6);
    sts_clr = 1;
    @(negedge clk);
    chk("t2_irq", irq, 1);
    chk("t2_clr_udf", clr_underflow, 1);
    chk("t2_set_wins", sts_udf, 1);
    chk("t2_sts_ovf", sts_ovf, 0);
    @(negedge clk);
    sts_clr = 0;
    chk("t2_udf_cleared", sts_udf, 0);
    chk("t2_idle", busy, 0);

    // DIV16 from 250: six ticks 16 apart, then overflow.
    go(8'd250, 1'b1, 2'd3, 1'b0, 1'b0, 100);
    chk("t3_first_tick", first_tick, 10);
    chk("t3_gap", gap, 16);
    chk("t3_ntick", ntick, 6);
    chk("t3_irq_at", irq_at, 92);
    chk("t3_idle_at", idle_at, 93);
    sts_clr = 1; @(negedge clk); sts_clr = 0;

    // Start while running, then stop in the same cycle as an overflow.
    go(8'd255, 1'b1, 2'd3, 1'b0, 1'b0, 3);
    cmd_start = 1; cmd_value = 8'h11; cmd_dir = 0; cmd_clk_sel = 2'd0;
    @(negedge clk);
    cmd_start = 0;
    chk("t4_cmd_err", cmd_err, 1);
    chk("t4_value_kept", start_counter, 8'd255);
    chk("t4_dir_kept", up_down, 1);
    @(negedge clk);
    chk("t4_err_pulse", cmd_err, 0);
    repeat (6) @(negedge clk);
    cmd_stop = 1;
    @(negedge clk);
    cmd_stop = 0;
    chk("t4_ovf_present", overflow, 1);
    chk("t4_no_irq", irq, 0);
    chk("t4_idle", busy, 0);
    chk("t4_enable", enable, 0);
    chk("t4_sticky", sts_ovf, 0);

    // Reset mid-run.
    rst = 1; @(negedge clk); rst = 0;
    go(8'd0, 1'b1, 2'd3, 1'b0, 1'b0, 5);
    chk("t5_running", enable, 1);
    rst = 1;
    @(negedge clk);
    chk("t5_reset_outputs", {clk_ena, start_counter, up_down, load, enable, clr_overflow,
        clr_underflow, busy, irq, cmd_err, sts_ovf, sts_udf}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("t5_no_clr", {clr_overflow, clr_underflow, busy}, 0);

    // Auto-reload request from 254, DIV2.
    go(8'd254, 1'b1, 2'd0, 1'b1, 1'b0, 40);
    chk("t6_irq_at", irq_at, 7);
    if (AR) begin
      chk("t6_nirq", nirq, 5);
      chk("t6_busy", busy, 1);
      cmd_stop = 1;
      @(negedge clk);
      cmd_stop = 0;
      chk("t6_stopped", busy, 0);
    end else begin
      chk("t6_nirq", nirq, 1);
      chk("t6_idle_at", idle_at, 8);
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
